mem_resp_unit: RTL and testbench
================================

# mem_resp_unit

Memory-side responder for the 512-bit line request interface that the control unit drives: it accepts single-cycle read and write requests, services them from an on-chip line store, and returns data_valid/read_data and write_done with fixed, parameterized latency. It also owns buffer_addr_valid and exposes a host-side port for preloading program and image lines and for reading back result lines. It sits between the host loader and the control unit.

## Interface
- DEPTH, 16384: number of 512-bit lines in the store.
- ADDR_W, 14: index width, equal to clog2(DEPTH).
- READ_LAT, 2: request-to-data_valid latency in cycles, minimum 1.
- WRITE_LAT, 1: request-to-write_done latency in cycles, minimum 1.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- address  in  32  line address of the ctrl-side request
- read_request_valid  in  1  ctrl read request, one line per cycle high
- write_request_valid  in  1  ctrl write request
- write_data  in  512  ctrl write line
- read_data  out  512  returned line, meaningful only with data_valid
- data_valid  out  1  single-cycle read-return strobe
- write_done  out  1  single-cycle write-complete strobe
- buffer_addr_valid  out  1  store loaded, control unit may start
- host_go  in  1  pulse: set buffer_addr_valid
- host_stop  in  1  pulse: clear buffer_addr_valid
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host line index
- host_wdata  in  512  host write line
- host_ack  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  512  host read line
- err_oob  out  1  sticky: ctrl address >= DEPTH seen
- err_collide  out  1  sticky: read and write requested in the same cycle

## Operation
- Ctrl port has absolute priority. host_ack = host_req & ~read_request_valid & ~write_request_valid. A host request that is not acked is held by the host until it is acked.
- Ctrl read accepted at edge T: the line at address[ADDR_W-1:0] is read. data_valid=1 and read_data are presented for one cycle at T+READ_LAT. Reads are fully pipelined, one per cycle, and return in order.
- Ctrl write accepted at edge T: the store is updated at edge T. write_done pulses at T+WRITE_LAT, one pulse per write, in order.
- Read/write same cycle: the write is performed, the read is dropped (no data_valid), and err_collide is set.
- Out of range (address >= DEPTH, all 32 bits compared): a read still returns data_valid with read_data = 0. A write is discarded but write_done still pulses. err_oob is set in both cases.
- Host read acked at T: host_rvalid=1 and host_rdata are presented at T+1 for one cycle. A host write acked at T updates the store at edge T.
- buffer_addr_valid: set by host_go, cleared by host_stop. If both are asserted in the same cycle, host_stop wins. Host access is allowed at any time, subject to arbitration.
- err flags clear only on reset.
- Implementation is a read pipeline shift register (valid + oob bits, data stage) of depth READ_LAT, plus a write_done shift register of depth WRITE_LAT.

## Timing
- Reset values: read_data=0, data_valid=0, write_done=0, buffer_addr_valid=0, host_ack=0 (combinational), host_rvalid=0, host_rdata=0, err_oob=0, err_collide=0. All pipeline valids are flushed, and in-flight requests are lost.
- Store contents are not reset.
- Read-after-write: a write at T followed by a read of the same address at T+1 returns the new data. A read and a host write to the same line cannot occur in the same cycle because of arbitration.
- Back-to-back reads every cycle give data_valid high continuously after READ_LAT cycles.
- A read issued on the same cycle that an earlier data_valid is high is accepted normally. This supports the control unit's chained image-page fetch.

## Test plan
- Preload: host writes lines 0..255 with value = index; host_go; ctrl reads address 0..255 one per cycle -> buffer_addr_valid=1, data_valid stream of 256 beats starting 2 cycles after the first request, read_data = 0..255 in order.
- Write/readback: ctrl write to address 100 with data 0xA5 repeated -> write_done 1 cycle later; host read of 100 -> host_rvalid next cycle, host_rdata = 0xA5 pattern.
- Arbitration: host_req held while ctrl reads for 5 cycles -> host_ack=0 for those 5 cycles, 1 on the first idle cycle, and host data is correct.
- Collision and out-of-range: read+write on the same cycle -> write lands, no data_valid, err_collide=1; read of address DEPTH+3 -> data_valid with read_data=0, err_oob=1; write to the same address -> write_done pulses, store unchanged.
- Reset mid-read: 2 reads in flight, rst_n low for 1 cycle -> no data_valid afterward, buffer_addr_valid=0, errors cleared.
- Latency sweep: READ_LAT=1 and 4, WRITE_LAT=3 -> strobes appear at exactly T+LAT for single requests and for bursts.

Source files
------------

// File: rtl/mem_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_unit
// Purpose  : 512-bit line store answering ctrl-side read/write requests with
//            fixed latency, plus an arbitrated host preload/readback port.
// Revision : 1.0
// ============================================================================
module mem_resp_unit #(
  parameter int DEPTH     = 16384,
  parameter int ADDR_W    = 14,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       address,
  input  logic              read_request_valid,
  input  logic              write_request_valid,
  input  logic [511:0]      write_data,
  output logic [511:0]      read_data,
  output logic              data_valid,
  output logic              write_done,
  output logic              buffer_addr_valid,
  input  logic              host_go,
  input  logic              host_stop,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [511:0]      host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [511:0]      host_rdata,
  output logic              err_oob,
  output logic              err_collide
);

  localparam logic [31:0] c_depth = 32'(DEPTH);

  logic [511:0]      r_mem [DEPTH];

  logic              w_oob;
  logic              w_rd_acc;
  logic [ADDR_W-1:0] w_idx;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [511:0]      w_mem_wdata;

  logic              r_rd_vld  [READ_LAT];
  logic              r_rd_oob  [READ_LAT];
  logic [511:0]      r_rd_data [READ_LAT];
  logic              r_wr_done [WRITE_LAT];

  logic              r_host_rvalid;
  logic [511:0]      r_host_rdata;
  logic              r_bav;
  logic              r_err_oob;
  logic              r_err_collide;

  assign w_oob    = (address >= c_depth);
  assign w_idx    = address[ADDR_W-1:0];
  // A colliding read is dropped; the write still proceeds.
  assign w_rd_acc = read_request_valid & ~write_request_valid;
  assign host_ack = rst_n & host_req & ~read_request_valid & ~write_request_valid;

  // Ctrl and host writes are mutually exclusive through arbitration.
  assign w_mem_we    = (write_request_valid & ~w_oob) | (host_ack & host_we);
  assign w_mem_addr  = write_request_valid ? w_idx : host_addr;
  assign w_mem_wdata = write_request_valid ? write_data : host_wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Data stages carry no reset; outputs are qualified by the valid stages.
  always_ff @(posedge clk) begin
    r_rd_data[0] <= r_mem[w_idx];
    for (int i = 1; i < READ_LAT; i++) begin
      r_rd_data[i] <= r_rd_data[i-1];
    end
    r_host_rdata <= r_mem[host_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        r_rd_vld[i] <= 1'b0;
        r_rd_oob[i] <= 1'b0;
      end
      for (int i = 0; i < WRITE_LAT; i++) begin
        r_wr_done[i] <= 1'b0;
      end
      r_host_rvalid <= 1'b0;
      r_bav         <= 1'b0;
      r_err_oob     <= 1'b0;
      r_err_collide <= 1'b0;
    end else begin
      r_rd_vld[0]  <= w_rd_acc;
      r_rd_oob[0]  <= w_oob;
      for (int i = 1; i < READ_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_oob[i] <= r_rd_oob[i-1];
      end
      r_wr_done[0] <= write_request_valid;
      for (int i = 1; i < WRITE_LAT; i++) begin
        r_wr_done[i] <= r_wr_done[i-1];
      end
      r_host_rvalid <= host_ack & ~host_we;
      if (host_stop) begin
        r_bav <= 1'b0;
      end else if (host_go) begin
        r_bav <= 1'b1;
      end
      if ((w_rd_acc | write_request_valid) & w_oob) begin
        r_err_oob <= 1'b1;
      end
      if (read_request_valid & write_request_valid) begin
        r_err_collide <= 1'b1;
      end
    end
  end

  assign data_valid        = r_rd_vld[READ_LAT-1];
  assign read_data         = (r_rd_vld[READ_LAT-1] & ~r_rd_oob[READ_LAT-1]) ?
                             r_rd_data[READ_LAT-1] : '0;
  assign write_done        = r_wr_done[WRITE_LAT-1];
  assign host_rvalid       = r_host_rvalid;
  assign host_rdata        = r_host_rvalid ? r_host_rdata : '0;
  assign buffer_addr_valid = r_bav;
  assign err_oob           = r_err_oob;
  assign err_collide       = r_err_collide;

endmodule
`default_nettype wire

// File: tb/tb_mem_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_resp_unit
// Purpose  : Directed bench for mem_resp_unit, default latencies plus a
//            READ_LAT=4 / WRITE_LAT=3 instance sharing the same stimulus.
// Revision : 1.0
// ============================================================================
module tb_mem_resp_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  address = '0;
  logic         read_request_valid = 1'b0;
  logic         write_request_valid = 1'b0;
  logic [511:0] write_data = '0;
  logic         host_go = 1'b0;
  logic         host_stop = 1'b0;
  logic         host_req = 1'b0;
  logic         host_we = 1'b0;
  logic [13:0]  host_addr = '0;
  logic [511:0] host_wdata = '0;

  logic [511:0] read_data, host_rdata;
  logic         data_valid, write_done, buffer_addr_valid, host_ack, host_rvalid;
  logic         err_oob, err_collide;

  logic [511:0] l_read_data, l_host_rdata;
  logic         l_data_valid, l_write_done, l_bav, l_host_ack, l_host_rvalid;
  logic         l_err_oob, l_err_collide;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_resp_unit u_dut (
    .clk(clk), .rst_n(rst_n), .address(address),
    .read_request_valid(read_request_valid), .write_request_valid(write_request_valid),
    .write_data(write_data), .read_data(read_data), .data_valid(data_valid),
    .write_done(write_done), .buffer_addr_valid(buffer_addr_valid),
    .host_go(host_go), .host_stop(host_stop), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .err_oob(err_oob), .err_collide(err_collide)
  );

  mem_resp_unit #(.DEPTH(256), .ADDR_W(8), .READ_LAT(4), .WRITE_LAT(3)) u_lat (
    .clk(clk), .rst_n(rst_n), .address(address),
    .read_request_valid(read_request_valid), .write_request_valid(write_request_valid),
    .write_data(write_data), .read_data(l_read_data), .data_valid(l_data_valid),
    .write_done(l_write_done), .buffer_addr_valid(l_bav),
    .host_go(host_go), .host_stop(host_stop), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr[7:0]), .host_wdata(host_wdata), .host_ack(l_host_ack),
    .host_rvalid(l_host_rvalid), .host_rdata(l_host_rdata),
    .err_oob(l_err_oob), .err_collide(l_err_collide)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: expectations are keyed by the edge index after which
  // the strobe must be visible.
  logic [511:0] mdl [int];
  logic [511:0] exp_rd [int];
  logic [511:0] exp_rd2 [int];
  logic [511:0] exp_hr [int];
  bit           exp_wd [int];
  bit           exp_wd2 [int];
  bit           m_oob = 1'b0, m_col = 1'b0, m_bav = 1'b0;
  int           ecount = 0;

  always @(negedge rst_n) begin
    exp_rd.delete(); exp_rd2.delete(); exp_hr.delete();
    exp_wd.delete(); exp_wd2.delete();
    m_oob = 1'b0; m_col = 1'b0; m_bav = 1'b0;
  end

  always @(posedge clk) begin
    int  e;
    bit  oob1, oob2;
    int  idx;
    e = ecount;
    ecount = ecount + 1;
    if (rst_n) begin
      oob1 = (address >= 32'd16384);
      oob2 = (address >= 32'd256);
      idx  = int'(address[13:0]);
      if (read_request_valid && !write_request_valid) begin
        exp_rd[e+1]  = oob1 ? 512'd0 : mdl[idx];
        exp_rd2[e+3] = oob2 ? 512'd0 : mdl[idx];
        if (oob1) m_oob = 1'b1;
      end
      if (read_request_valid && write_request_valid) m_col = 1'b1;
      if (write_request_valid) begin
        exp_wd[e]    = 1'b1;
        exp_wd2[e+2] = 1'b1;
        if (oob1) m_oob = 1'b1;
        else mdl[idx] = write_data;
      end
      if (host_req && !read_request_valid && !write_request_valid) begin
        if (host_we) mdl[int'(host_addr)] = host_wdata;
        else exp_hr[e] = mdl[int'(host_addr)];
      end
      if (host_stop) m_bav = 1'b0;
      else if (host_go) m_bav = 1'b1;
    end
  end

  always @(negedge clk) begin
    int e;
    if (ecount > 0) begin
      e = ecount - 1;
      chk("data_valid", data_valid, exp_rd.exists(e) ? 1'b1 : 1'b0);
      if (exp_rd.exists(e)) chk("read_data", read_data, exp_rd[e]);
      chk("write_done", write_done, exp_wd.exists(e) ? 1'b1 : 1'b0);
      chk("host_rvalid", host_rvalid, exp_hr.exists(e) ? 1'b1 : 1'b0);
      if (exp_hr.exists(e)) chk("host_rdata", host_rdata, exp_hr[e]);
      chk("host_ack", host_ack, rst_n & host_req & ~read_request_valid & ~write_request_valid);
      chk("buffer_addr_valid", buffer_addr_valid, m_bav);
      chk("err_oob", err_oob, m_oob);
      chk("err_collide", err_collide, m_col);
      chk("lat_data_valid", l_data_valid, exp_rd2.exists(e) ? 1'b1 : 1'b0);
      if (exp_rd2.exists(e)) chk("lat_read_data", l_read_data, exp_rd2[e]);
      chk("lat_write_done", l_write_done, exp_wd2.exists(e) ? 1'b1 : 1'b0);
      chk("lat_host_rvalid", l_host_rvalid, exp_hr.exists(e) ? 1'b1 : 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    read_request_valid = 1'b0; write_request_valid = 1'b0;
    host_req = 1'b0; host_go = 1'b0; host_stop = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ctrl_rd(input logic [31:0] a);
    read_request_valid = 1'b1; write_request_valid = 1'b0; address = a;
    step();
  endtask

  task automatic ctrl_wr(input logic [31:0] a, input logic [511:0] d);
    read_request_valid = 1'b0; write_request_valid = 1'b1; address = a; write_data = d;
    step();
  endtask

  initial begin
    #3;
    chk("rst_read_data", read_data, 512'd0);
    chk("rst_host_rdata", host_rdata, 512'd0);
    chk("rst_host_ack", host_ack, 1'b0);
    step(); step();
    rst_n = 1'b1;

    // Preload lines 0..255 with their own index, then start the control unit.
    host_req = 1'b1; host_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      host_addr = 14'(i); host_wdata = 512'(i);
      step();
    end
    host_req = 1'b0;
    host_go = 1'b1; step(); host_go = 1'b0;
    for (int i = 0; i < 256; i++) ctrl_rd(32'(i));
    idle(6);

    // Write 0xA5 line, read it back through the host port.
    ctrl_wr(32'd100, {64{8'hA5}});
    read_request_valid = 1'b0; write_request_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'd100;
    step();
    idle(4);

    // Host read held off by five ctrl reads.
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'd7;
    for (int i = 1; i <= 5; i++) begin
      read_request_valid = 1'b1; address = 32'(i);
      step();
    end
    read_request_valid = 1'b0;
    step();
    idle(6);

    // Read-after-write on the next cycle.
    ctrl_wr(32'd5, {16{32'h1234_5678}});
    ctrl_rd(32'd5);
    idle(6);

    // Collision: write lands, read dropped.
    read_request_valid = 1'b1; write_request_valid = 1'b1;
    address = 32'd10; write_data = {64{8'hC3}};
    step();
    idle(2);
    ctrl_rd(32'd10);
    idle(6);

    // Out of range reads and a discarded write aliasing line 3.
    ctrl_rd(32'd16387);
    ctrl_wr(32'd16387, {512{1'b1}});
    ctrl_rd(32'h8000_0003);
    idle(1);
    ctrl_rd(32'd3);
    idle(6);

    // go and stop together: stop wins.
    host_go = 1'b1; host_stop = 1'b1; step();
    host_go = 1'b1; host_stop = 1'b0; step();
    idle(2);

    // Reset with two reads in flight.
    ctrl_rd(32'd1);
    ctrl_rd(32'd2);
    read_request_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(8);

    // Burst after reset for both latency settings.
    for (int i = 20; i < 28; i++) ctrl_rd(32'(i));
    ctrl_wr(32'd30, 512'hBEEF);
    ctrl_wr(32'd31, 512'hCAFE);
    ctrl_rd(32'd30);
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
